// File: rtl/cpu_bus_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the shared slave port.
// The arbiter uses modport slave; the surrounding masters and memory use modport master.
interface cpu_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]          iMReadEnable;
    logic [NUM_MASTERS-1:0]          iMWriteEnable;
    logic [NUM_MASTERS*DATA_W/8-1:0] iMByteEnable;
    logic [NUM_MASTERS*DATA_W-1:0]   iMWriteData;
    logic [NUM_MASTERS*ADDR_W-1:0]   iMAddress;
    logic [DATA_W-1:0]               oMReadData;
    logic [NUM_MASTERS-1:0]          oMReady;
    logic [NUM_MASTERS-1:0]          oMError;
    logic [2:0]                      oGrant;
    logic                            oSReadEnable;
    logic                            oSWriteEnable;
    logic [DATA_W/8-1:0]             oSByteEnable;
    logic [DATA_W-1:0]               oSWriteData;
    logic [ADDR_W-1:0]               oSAddress;
    logic [DATA_W-1:0]               iSReadData;
    logic                            iSReady;

    modport slave (
        input  iMReadEnable, iMWriteEnable, iMByteEnable, iMWriteData, iMAddress,
        input  iSReadData, iSReady,
        output oMReadData, oMReady, oMError, oGrant,
        output oSReadEnable, oSWriteEnable, oSByteEnable, oSWriteData, oSAddress
    );

    modport master (
        output iMReadEnable, iMWriteEnable, iMByteEnable, iMWriteData, iMAddress,
        output iSReadData, iSReady,
        input  oMReadData, oMReady, oMError, oGrant,
        input  oSReadEnable, oSWriteEnable, oSByteEnable, oSWriteData, oSAddress
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// N-master arbiter onto one slave port: IDLE -> ACCESS -> RESP with a wait-state watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module cpu_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input logic              iCLK,
    input logic              iRST,
    cpu_bus_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                 r_state;
    logic [2:0]             r_grant;
    logic                   r_srd;
    logic                   r_swr;
    logic [BE_W-1:0]        r_sbe;
    logic [DATA_W-1:0]      r_swdata;
    logic [ADDR_W-1:0]      r_saddr;
    logic [DATA_W-1:0]      r_rdata;
    logic [NUM_MASTERS-1:0] r_ready;
    logic [NUM_MASTERS-1:0] r_error;
    logic [7:0]             r_wait;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_rdsh;
    logic [NUM_MASTERS-1:0] w_wrsh;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic [2:0]             w_start;
    logic [2:0]             w_win;
    logic                   w_any;
    logic                   w_rd;
    logic                   w_wr;
    logic [BE_W-1:0]        w_be;
    logic [DATA_W-1:0]      w_wdata;
    logic [ADDR_W-1:0]      w_addr;
    logic                   w_timeout;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    assign w_start = r_ptr;
`else
    assign w_start = 3'd0;
`endif

    // Walk the search order backwards so the first requester from start wins.
    function automatic logic [2:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                          input logic [2:0] start);
        int                     idx;
        logic [NUM_MASTERS-1:0] sh;
        logic [2:0]             win;
        win = 3'd0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_MASTERS;
            sh  = req >> idx;
            if (sh[0]) win = idx[2:0];
        end
        return win;
    endfunction

    assign w_req     = bus.iMReadEnable | bus.iMWriteEnable;
    assign w_any     = |w_req;
    assign w_win     = f_pick(w_req, w_start);
    assign w_rdsh    = bus.iMReadEnable >> w_win;
    assign w_wrsh    = bus.iMWriteEnable >> w_win;
    assign w_rd      = w_rdsh[0];
    assign w_wr      = w_wrsh[0];
    assign w_be      = BE_W'(bus.iMByteEnable >> (int'(w_win) * BE_W));
    assign w_wdata   = DATA_W'(bus.iMWriteData >> (int'(w_win) * DATA_W));
    assign w_addr    = ADDR_W'(bus.iMAddress >> (int'(w_win) * ADDR_W));
    assign w_onehot  = NUM_MASTERS'(1) << r_grant;
    assign w_timeout = (TIMEOUT != 0) && (r_wait >= 8'(TIMEOUT));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= S_IDLE;
            r_grant  <= 3'd0;
            r_srd    <= 1'b0;
            r_swr    <= 1'b0;
            r_sbe    <= '0;
            r_swdata <= '0;
            r_saddr  <= '0;
            r_rdata  <= '0;
            r_ready  <= '0;
            r_error  <= '0;
            r_wait   <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr    <= 3'd0;
`endif
        end else begin
            r_ready <= '0;
            r_error <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_win;
                        r_srd    <= w_rd & ~w_wr;
                        r_swr    <= w_wr;
                        r_sbe    <= w_be;
                        r_swdata <= w_wdata;
                        r_saddr  <= w_addr;
                        r_wait   <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr    <= 3'((int'(w_win) + 1) % NUM_MASTERS);
`endif
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
                    // Slave completion takes precedence over a watchdog expiring the same cycle.
                    if (bus.iSReady) begin
                        if (r_srd) r_rdata <= bus.iSReadData;
                        r_srd   <= 1'b0;
                        r_swr   <= 1'b0;
                        r_ready <= w_onehot;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_srd   <= 1'b0;
                        r_swr   <= 1'b0;
                        r_ready <= w_onehot;
                        r_error <= w_onehot;
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.oMReadData    = r_rdata;
    assign bus.oMReady       = r_ready;
    assign bus.oMError       = r_error;
    assign bus.oGrant        = r_grant;
    assign bus.oSReadEnable  = r_srd;
    assign bus.oSWriteEnable = r_swr;
    assign bus.oSByteEnable  = r_sbe;
    assign bus.oSWriteData   = r_swdata;
    assign bus.oSAddress     = r_saddr;
endmodule
